// File: rtl/ysyx_22040175_dmem_resp.sv
// Fixed-latency data memory responder for the core load/store port.
// Optional address range checking is enabled by defining YSYX_22040175_DMEM_RANGE_CHECK_EN.
module ysyx_22040175_dmem_resp #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 64,
  parameter int              DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int              LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | counting down the access latency
  // S_RESP | response presented, waiting for resp_ready
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                req_ready_nxt, resp_valid_nxt;
  logic                accept, do_access;

  logic                lat_wen;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [7:0]          lat_wmask;

  logic                acc_wen;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [7:0]          acc_wmask;
  logic [ADDR_W-1:0]   off;
  logic [IDX_W-1:0]    idx;
  logic                in_range;
  logic                unused_bits;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign accept = req_valid && req_ready && (state == S_IDLE);

  // With LATENCY=1 the access happens on the accept edge, before the latches hold the request.
  assign acc_wen   = (state == S_IDLE) ? req_wen   : lat_wen;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign acc_wmask = (state == S_IDLE) ? req_wmask : lat_wmask;

  assign off = acc_addr - BASE_ADDR;
  assign idx = off[IDX_W+2:3];
  assign unused_bits = ^{off[2:0], off[ADDR_W-1:IDX_W+3]};

`ifdef YSYX_22040175_DMEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * 8);
  assign in_range = ({1'b0, off} < SPAN);
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
          do_access = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_valid && resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    req_ready_nxt  = (state_nxt == S_IDLE);
    resp_valid_nxt = (state_nxt == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_wen    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      if (accept) begin
        lat_wen   <= req_wen;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wmask <= req_wmask;
      end
      if (do_access) begin
        resp_rdata <= (acc_wen || !in_range) ? '0 : mem[idx];
`ifdef YSYX_22040175_DMEM_RANGE_CHECK_EN
        resp_err   <= !in_range;
`else
        resp_err   <= 1'b0;
`endif
      end
    end
  end

  // Array is not reset; a reset edge also suppresses a store still in flight.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && acc_wen && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (acc_wmask[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040175_dmem_resp.sv
// Randomized self-checking bench for ysyx_22040175_dmem_resp against a word-array model.
// Build with YSYX_22040175_DMEM_RANGE_CHECK_EN defined to exercise the range-check variant.
module tb_ysyx_22040175_dmem_resp;
  localparam int          ADDR_W  = 32;
  localparam int          DEPTH   = 1024;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic [63:0] model [DEPTH];
  int checks   = 0;
  int failures = 0;

  ysyx_22040175_dmem_resp #(
    .ADDR_W(ADDR_W), .DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: word index from byte offset, optional range rule, byte-enable merge.
  task automatic model_op(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask, output logic [63:0] er, output logic ee);
    logic [31:0] off;
    int          idx;
    bit          inr;
    off = addr - BASE;
    idx = int'(off >> 3) % DEPTH;
`ifdef YSYX_22040175_DMEM_RANGE_CHECK_EN
    inr = (off < 32'(DEPTH * 8));
`else
    inr = 1'b1;
`endif
    ee = !inr;
    er = '0;
    if (inr) begin
      if (!wen) er = model[idx];
      else for (int b = 0; b < 8; b++)
        if (wmask[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  task automatic drive_junk(input bit junk);
    if (junk) begin
      req_valid = 1'($urandom % 2);
      req_wen   = 1'($urandom % 2);
      req_addr  = $urandom;
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'($urandom);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input int stall, input bit junk);
    logic [63:0] er;
    logic        ee;
    int          lat, w;
    model_op(wen, addr, wdata, wmask, er, ee);
    w = 0;
    while (req_ready !== 1'b1 && w < 32) begin @(negedge clk); w++; end
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    chk("req_ready_drop", 64'(req_ready), 64'd0);
    drive_junk(junk);
    while (resp_valid !== 1'b1 && lat < 32) begin
      @(negedge clk);
      lat++;
      drive_junk(junk);
    end
    chk("latency", 64'(lat), 64'(LATENCY));
    chk("rdata", resp_rdata, er);
    chk("err", 64'(resp_err), 64'(ee));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      drive_junk(junk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, er);
      chk("hold_err", 64'(resp_err), 64'(ee));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_done", 64'(resp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_ctrl", {61'd0, req_ready, resp_valid, resp_err}, 64'd0);
      chk("reset_rdata", resp_rdata, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    for (int i = 0; i < DEPTH; i++)
      run_txn(1'b1, BASE + 32'(i * 8), {$urandom, $urandom}, 8'hFF, 0, 1'b0);

    run_txn(1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, 0, 1'b0);
    run_txn(1'b0, 32'h8000_0010, 64'h0, 8'h00, 0, 1'b0);
    run_txn(1'b1, 32'h8000_0010, 64'hAAAA_BBBB_0000_0000, 8'hF0, 0, 1'b0);
    run_txn(1'b0, 32'h8000_0010, 64'h0, 8'h00, 0, 1'b0);
    chk("merge_model", model[2], 64'hAAAABBBB55667788);

    // Backpressure: five cycles with resp_ready low while junk requests are offered.
    run_txn(1'b0, 32'h8000_0010, 64'h0, 8'h00, 4, 1'b1);

    // Abort a store in flight with a reset; the model is deliberately not updated.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
    req_wdata = ~model[4]; req_wmask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midreset_ctrl", {61'd0, req_ready, resp_valid, resp_err}, 64'd0);
      chk("midreset_rdata", resp_rdata, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 64'(req_ready), 64'd1);
    run_txn(1'b0, 32'h8000_0020, 64'h0, 8'h00, 0, 1'b0);

    run_txn(1'b0, 32'h8000_2000, 64'h0, 8'h00, 0, 1'b0);
    run_txn(1'b1, 32'h7FFF_FFF8, {$urandom, $urandom}, 8'hFF, 0, 1'b0);
    run_txn(1'b0, 32'h8000_1FF8, 64'h0, 8'h00, 0, 1'b0);
    run_txn(1'b1, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 1'b0);
    run_txn(1'b0, 32'h8000_0008, 64'h0, 8'h00, 0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom % 4 == 0) a = $urandom;
      else a = BASE + 32'(($urandom % DEPTH) * 8) + 32'($urandom % 8);
      run_txn(1'($urandom % 2), a, {$urandom, $urandom}, 8'($urandom),
              int'($urandom % 4), 1'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
